regfile_sb: RTL and testbench
=============================

# regfile_sb

Three-port 32×32 general-purpose register file with a per-register pending-write scoreboard. It sits directly upstream of the ALU:
- Read port A drives the ALU `a` operand; read port B drives the ALU `b` operand.
- The write port takes back the ALU result `s` or a memory load.
- The scoreboard marks registers whose write-back is still outstanding, for example multi-cycle loads. When an instruction reads such a register, the block raises `stall` to hold the pipeline.

## Interface
Parameters:
- DW, 32, data width
- AW, 5, register-number width (2^AW registers)

Ports:
- clock  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- rna  in  AW  read port A register number
- rnb  in  AW  read port B register number
- use_a  in  1  current instruction consumes port A
- use_b  in  1  current instruction consumes port B
- qa  out  DW  read data A (to ALU a)
- qb  out  DW  read data B (to ALU b)
- we  in  1  write enable
- wn  in  AW  write register number
- d  in  DW  write data (ALU s or load data)
- issue  in  1  mark destination pending
- issue_rd  in  AW  destination register being marked pending
- stall  out  1  hazard: a used source is pending
- busy  out  2^AW  scoreboard vector, for debug and verification

## Operation
- **Register 0:**
  - Reads always return 0.
  - Writes to register 0 are discarded.
  - issue_rd == 0 is ignored; busy[0] is never set.
- **Reads:** combinational. qa = R[rna], qb = R[rnb].
- **Writes:** on the rising edge with we=1 and wn≠0, R[wn] ← d.
- **Scoreboard set/clear:**
  - On an edge with issue=1, stall=0 and issue_rd≠0, busy[issue_rd] ← 1.
  - On an edge with we=1 and wn≠0, busy[wn] ← 0.
  - If the set and the clear target the same register on the same edge, set wins. This is a new outstanding producer.
- **Issue gating:** while stall=1, issue is ignored, so a stalled instruction does not mark its destination.
- **stall:** `(use_a & busy[rna]) | (use_b & busy[rnb])`, combinational. Register 0 never stalls.
- **Reset:**
  - All registers ← 0.
  - All busy bits ← 0.
  - Consequences: stall=0, and qa=qb=0 for any addresses.
  - Reset overrides any write or issue on the same edge.
- **Mid-operation reset:** outstanding pending entries are dropped. A later write-back to a register whose busy bit is clear is still performed; a clear of an already-clear bit has no effect.

## Timing
- **Read latency:** 0 cycles, combinational from rna/rnb.
- **Write latency:** 1 edge. Without bypass, a value written at edge N is visible on qa/qb after edge N.
- **Busy set/clear:** visible after the edge on which it occurs.
- **stall:** combinational in the same cycle as rna/rnb/use_*. It deasserts in the cycle after the clearing write edge, or in the same cycle when bypass is enabled.
- **Issue back-to-back:** issue for the same rd on consecutive cycles keeps busy set; a single write clears it.

## Configuration
- **REGFILE_BYPASS_EN defined:** write-through forwarding.
  - When we=1, wn≠0 and wn==rna, qa=d in the same cycle; likewise for wn==rnb and qb.
  - The stall term for that source is masked in the same cycle. A write-back arriving this cycle satisfies a pending read.
  - An issue and a write to the same rd on the same edge still leave busy set.
- **REGFILE_BYPASS_EN not defined:**
  - qa/qb show only stored values.
  - stall stays asserted through the write cycle and drops one cycle later.

## Structure
- **Shared package `regfile_pkg`:** DW, AW, NREG = 2**AW, and REG_ZERO = 0. It is also used by the decoder and write-back mux.
- **Sub-module `regfile_scoreboard`:** owns the busy vector, the set/clear priority and the stall equation. The top level holds the storage array and the read muxes.

## Test plan
- **Reset:** assert reset with prior writes present → qa=qb=0 for all rna/rnb, busy=0, stall=0.
- **Register 0:** write d=32'hDEADBEEF to wn=0 → qa with rna=0 reads 0. Issue with issue_rd=0 → busy[0] stays 0.
- **Write then read:** write 32'h12345678 to R5 → after the edge, rna=5 gives qa=32'h12345678. In the write cycle, qa is the old value without the macro and 32'h12345678 with REGFILE_BYPASS_EN.
- **Load-use hazard:**
  - issue R7, then read rnb=7 with use_b=1 → stall=1.
  - Write R7 with we=1 → stall=0 after the edge (without the macro) or in the write cycle (with it).
- **Simultaneous events:**
  - Issue R9 and write R9 on the same edge → busy[9]=1 afterwards.
  - Issue while stall=1 → busy unchanged.
- **Mid-operation reset:** issue R3, reset, then write R3=32'h1 → busy[3]=0 throughout, and R3 reads 32'h1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file, operand decoder and write-back mux.
// The REGFILE_BYPASS_EN macro (see regfile_sb) does not change anything here.
package regfile_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NREG     = 2 ** AW;
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and cleared on write-back.
// Build option: REGFILE_BYPASS_EN lets a write-back arriving this cycle satisfy a pending read.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW = regfile_pkg::AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     rna,
    input  logic [AW-1:0]     rnb,
    input  logic              use_a,
    input  logic              use_b,
    input  logic              we,
    input  logic [AW-1:0]     wn,
    input  logic              issue,
    input  logic [AW-1:0]     issue_rd,
    output logic              stall,
    output logic [2**AW-1:0]  busy
);

    localparam int unsigned NR = 2 ** AW;

    logic [NR-1:0] busy_q, busy_d;
    logic          wr_en, set_en;
    logic          hit_a, hit_b;

    assign wr_en  = we && (wn != AW'(REG_ZERO));
    assign set_en = issue && !stall && (issue_rd != AW'(REG_ZERO));

    always_comb begin
        hit_a = use_a && busy_q[rna];
        hit_b = use_b && busy_q[rnb];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wn == rna)) hit_a = 1'b0;
        if (wr_en && (wn == rnb)) hit_b = 1'b0;
`endif
        stall = hit_a || hit_b;
    end

    // Clear first so a same-edge issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)  busy_d[wn]       = 1'b0;
        if (set_en) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Three-port 2^AW x DW register file with pending-write scoreboard; R0 reads as zero.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding to qa/qb.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DW = regfile_pkg::DW,
    parameter int unsigned AW = regfile_pkg::AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     rna,
    input  logic [AW-1:0]     rnb,
    input  logic              use_a,
    input  logic              use_b,
    output logic [DW-1:0]     qa,
    output logic [DW-1:0]     qb,
    input  logic              we,
    input  logic [AW-1:0]     wn,
    input  logic [DW-1:0]     d,
    input  logic              issue,
    input  logic [AW-1:0]     issue_rd,
    output logic              stall,
    output logic [2**AW-1:0]  busy
);

    localparam int unsigned NR = 2 ** AW;

    logic [DW-1:0] regs_q [NR];
    logic          wr_en;

    assign wr_en = we && (wn != AW'(REG_ZERO));

    // Entry 0 is reset to zero and never written, so it reads back as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NR); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wn] <= d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign qa = (wr_en && (wn == rna)) ? d : regs_q[rna];
    assign qb = (wr_en && (wn == rnb)) ? d : regs_q[rnb];
`else
    assign qa = regs_q[rna];
    assign qb = regs_q[rnb];
`endif

    regfile_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .rna      (rna),
        .rnb      (rnb),
        .use_a    (use_a),
        .use_b    (use_b),
        .we       (we),
        .wn       (wn),
        .issue    (issue),
        .issue_rd (issue_rd),
        .stall    (stall),
        .busy     (busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rna, rnb, wn, issue_rd;
    logic          use_a, use_b, we, issue;
    logic [DW-1:0] d, qa, qb;
    logic          stall;
    logic [31:0]   busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock    (clock),
        .reset    (reset),
        .rna      (rna),
        .rnb      (rnb),
        .use_a    (use_a),
        .use_b    (use_b),
        .qa       (qa),
        .qb       (qb),
        .we       (we),
        .wn       (wn),
        .d        (d),
        .issue    (issue),
        .issue_rd (issue_rd),
        .stall    (stall),
        .busy     (busy)
    );

    task automatic idle();
        reset = 1'b0; we = 1'b0; issue = 1'b0; use_a = 1'b0; use_b = 1'b0;
        rna = '0; rnb = '0; wn = '0; issue_rd = '0; d = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        // Populate state, then check it is all wiped.
        idle();
        we = 1'b1; wn = 5'd1; d = 32'hAAAA_0001; tick();
        wn = 5'd2; d = 32'hBBBB_0002; tick();
        we = 1'b0; issue = 1'b1; issue_rd = 5'd4; tick();
        issue = 1'b0; rna = 5'd1; rnb = 5'd2; #1;
        n_cmp++;
        if (qa !== 32'hAAAA_0001) begin
            n_fail++; $display("FAIL pre_reset_qa got=%h want=%h", qa, 32'hAAAA_0001);
        end
        n_cmp++;
        if (busy !== 32'h0000_0010) begin
            n_fail++; $display("FAIL pre_reset_busy got=%h want=%h", busy, 32'h0000_0010);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL reset_busy got=%h want=0", busy);
        end
        use_a = 1'b1; use_b = 1'b1; rna = 5'd4; rnb = 5'd4; #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got=%b want=0", stall);
        end
        for (int i = 0; i < 32; i++) begin
            rna = AW'(i); rnb = AW'(31 - i); #1;
            n_cmp++;
            if (qa !== 32'h0 || qb !== 32'h0) begin
                n_fail++; $display("FAIL reset_read[%0d] qa=%h qb=%h want=0", i, qa, qb);
            end
        end
        idle();
    endtask

    task automatic test_reg0();
        idle();
        we = 1'b1; wn = 5'd0; d = 32'hDEAD_BEEF; rna = 5'd0; #1;
        n_cmp++;
        if (qa !== 32'h0) begin
            n_fail++; $display("FAIL r0_write_cycle got=%h want=0", qa);
        end
        tick(); we = 1'b0; #1;
        n_cmp++;
        if (qa !== 32'h0) begin
            n_fail++; $display("FAIL r0_after_write got=%h want=0", qa);
        end
        issue = 1'b1; issue_rd = 5'd0; tick(); issue = 1'b0;
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL r0_issue_busy got=%h want=0", busy);
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 1'b1; wn = 5'd5; d = 32'h1234_5678; rna = 5'd5; rnb = 5'd5; #1;
        n_cmp++;
        if (qa !== (BYP ? 32'h1234_5678 : 32'h0)) begin
            n_fail++;
            $display("FAIL wr_cycle_qa got=%h want=%h", qa, BYP ? 32'h1234_5678 : 32'h0);
        end
        tick(); we = 1'b0; d = 32'h0; #1;
        n_cmp++;
        if (qa !== 32'h1234_5678 || qb !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wr_after qa=%h qb=%h want=12345678", qa, qb);
        end
        rna = 5'd1; #1;
        n_cmp++;
        if (qa !== 32'h0) begin
            n_fail++; $display("FAIL wr_other_reg got=%h want=0", qa);
        end
    endtask

    task automatic test_hazard();
        idle();
        issue = 1'b1; issue_rd = 5'd7; tick(); issue = 1'b0;
        rnb = 5'd7; use_b = 1'b1; #1;
        n_cmp++;
        if (stall !== 1'b1 || busy !== 32'h0000_0080) begin
            n_fail++; $display("FAIL hz_stall stall=%b busy=%h want=1/00000080", stall, busy);
        end
        use_b = 1'b0; #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL hz_unused got=%b want=0", stall);
        end
        use_b = 1'b1; we = 1'b1; wn = 5'd7; d = 32'hCAFE_0007; #1;
        n_cmp++;
        if (stall !== !BYP) begin
            n_fail++; $display("FAIL hz_write_cycle_stall got=%b want=%b", stall, !BYP);
        end
        n_cmp++;
        if (qb !== (BYP ? 32'hCAFE_0007 : 32'h0)) begin
            n_fail++;
            $display("FAIL hz_write_cycle_qb got=%h want=%h", qb, BYP ? 32'hCAFE_0007 : 32'h0);
        end
        tick(); we = 1'b0; #1;
        n_cmp++;
        if (stall !== 1'b0 || busy !== 32'h0 || qb !== 32'hCAFE_0007) begin
            n_fail++;
            $display("FAIL hz_after stall=%b busy=%h qb=%h want=0/0/cafe0007", stall, busy, qb);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        issue = 1'b1; issue_rd = 5'd9; we = 1'b1; wn = 5'd9; d = 32'h9; tick();
        issue = 1'b0; we = 1'b0;
        n_cmp++;
        if (busy !== 32'h0000_0200) begin
            n_fail++; $display("FAIL same_edge_busy got=%h want=00000200", busy);
        end
        rna = 5'd9; use_a = 1'b1; issue = 1'b1; issue_rd = 5'd10; #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL gated_stall got=%b want=1", stall);
        end
        tick(); issue = 1'b0;
        n_cmp++;
        if (busy !== 32'h0000_0200) begin
            n_fail++; $display("FAIL gated_issue_busy got=%h want=00000200", busy);
        end
        use_a = 1'b0; we = 1'b1; wn = 5'd9; d = 32'h99; tick(); we = 1'b0;
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL clear9_busy got=%h want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        issue = 1'b1; issue_rd = 5'd11; tick(); tick(); issue = 1'b0;
        n_cmp++;
        if (busy !== 32'h0000_0800) begin
            n_fail++; $display("FAIL b2b_busy got=%h want=00000800", busy);
        end
        we = 1'b1; wn = 5'd11; d = 32'hB; tick(); we = 1'b0;
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL b2b_clear got=%h want=0", busy);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        issue = 1'b1; issue_rd = 5'd3; tick(); issue = 1'b0;
        n_cmp++;
        if (busy !== 32'h0000_0008) begin
            n_fail++; $display("FAIL mid_issue_busy got=%h want=00000008", busy);
        end
        // Reset must win over a same-edge write and issue.
        reset = 1'b1; we = 1'b1; wn = 5'd6; d = 32'h66; issue = 1'b1; issue_rd = 5'd12;
        tick();
        idle(); rna = 5'd6; #1;
        n_cmp++;
        if (busy !== 32'h0 || qa !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset busy=%h qa=%h want=0/0", busy, qa);
        end
        we = 1'b1; wn = 5'd3; d = 32'h1; rna = 5'd3; tick(); we = 1'b0; #1;
        n_cmp++;
        if (busy !== 32'h0 || qa !== 32'h1) begin
            n_fail++; $display("FAIL mid_writeback busy=%h qa=%h want=0/1", busy, qa);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        test_reset();
        test_reg0();
        test_write_read();
        test_hazard();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
